// File: rtl/design1_mux8_if.sv
// Bus bundle for the registered 8-to-1 bit selector.
// The master side drives the data bus, select, enable and inhibit.
// The slave side (the selector) returns the registered output bit.
interface design1_mux8_if #(
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] DATA_IN;
    logic [SEL_W-1:0]  S;
    logic              EN_0;
    logic              GND;
    logic              DATA_OUT;

    modport master (
        output DATA_IN,
        output S,
        output EN_0,
        output GND,
        input  DATA_OUT
    );

    modport slave (
        input  DATA_IN,
        input  S,
        input  EN_0,
        input  GND,
        output DATA_OUT
    );
endinterface

// File: rtl/design1_mux8.sv
// Registered 8-to-1 bit selector with enable and ground-reference inhibit.
// Stage 1 registers the raw inputs together, so S and DATA_IN never mix
// values from different cycles. Stage 2 forms EN_0 & ~GND & DATA_IN[S]
// from those registered values and drives DATA_OUT.
// Reset asserts asynchronously; its release is synchronised by a 2-flop
// chain. Stage 1 starts loading on the second rising edge after rst_n
// rises, and stage 2 one edge later.
module design1_mux8 #(
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    design1_mux8_if.slave bus
);

    // Every select code must map onto a real data bit.
    generate
        if (DATA_W != (1 << SEL_W)) begin : g_bad_width
            $error("design1_mux8: DATA_W must equal 2**SEL_W");
        end
    endgenerate

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic [DATA_W-1:0] data_in_q,  data_in_d;
    logic [SEL_W-1:0]  s_q,        s_d;
    logic              en_q,       en_d;
    logic              gnd_q,      gnd_d;
    logic              data_out_q, data_out_d;

    // Release chain: shifts ones in after rst_n rises.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Release-chain flops; cleared the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Stage 1: capture all inputs together once the first sync flop is set.
    // rst_sync_q[0] is the next value of rst_sync_q[1], so stage 1 loads on
    // the same edge that completes the release.
    always_comb begin
        data_in_d = data_in_q;
        s_d       = s_q;
        en_d      = en_q;
        gnd_d     = gnd_q;
        if (rst_sync_q[0]) begin
            data_in_d = bus.DATA_IN;
            s_d       = bus.S;
            en_d      = bus.EN_0;
            gnd_d     = bus.GND;
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in_q <= '0;
            s_q       <= '0;
            en_q      <= 1'b0;
            gnd_q     <= 1'b0;
        end else begin
            data_in_q <= data_in_d;
            s_q       <= s_d;
            en_q      <= en_d;
            gnd_q     <= gnd_d;
        end
    end

    // Stage 2: select the bit. GND overrides EN_0, and both gate the data.
    always_comb begin
        data_out_d = data_out_q;
        if (rst_sync_q[1]) begin
            data_out_d = en_q & ~gnd_q & data_in_q[s_q];
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.DATA_OUT = data_out_q;

endmodule

// File: tb/tb_design1_mux8.sv
// Self-checking bench for design1_mux8.
// Inputs are driven on the falling edge. DATA_OUT is sampled on the
// falling edge, just before new inputs are driven. A value driven at
// falling edge n is captured at the next rising edge and appears on
// DATA_OUT after the rising edge that follows. It is therefore visible at
// falling edge n+2.
// After a reset release at falling edge m, the first capture is of the
// inputs driven at m+1. The output becomes meaningful from falling edge
// m+3 and is 0 before that.
module tb_design1_mux8;

    logic clk;
    logic rst_n;

    design1_mux8_if #(.SEL_W(3), .DATA_W(8)) bus ();

    design1_mux8 #(.SEL_W(3), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int since_rel;

    // History of driven inputs: index 0 is the last falling edge,
    // index 1 is the falling edge before that.
    logic [7:0] h_d  [2];
    logic [2:0] h_s  [2];
    logic       h_en [2];
    logic       h_g  [2];

    // Reference rule: the output is the data bit at position s, shown only
    // when enabled and not inhibited.
    function automatic logic ref_bit(input logic [7:0] d, input logic [2:0] s,
                                     input logic en, input logic g);
        int shifted;
        if (!en || g) return 1'b0;
        shifted = int'(d) >> int'(s);
        return logic'(shifted % 2);
    endfunction

    task automatic drive(input logic [7:0] d, input logic [2:0] s,
                         input logic en, input logic g);
        h_d[1] = h_d[0]; h_s[1] = h_s[0]; h_en[1] = h_en[0]; h_g[1] = h_g[0];
        h_d[0] = d;      h_s[0] = s;      h_en[0] = en;      h_g[0] = g;
        bus.DATA_IN = d;
        bus.S       = s;
        bus.EN_0    = en;
        bus.GND     = g;
    endtask

    // Advance one falling edge, sample the output and form its expected
    // value, then drive the next inputs.
    task automatic step(input logic [7:0] d, input logic [2:0] s,
                        input logic en, input logic g,
                        output logic exp_o, output logic act_o);
        @(negedge clk);
        since_rel++;
        act_o = bus.DATA_OUT;
        exp_o = (since_rel >= 3) ? ref_bit(h_d[1], h_s[1], h_en[1], h_g[1]) : 1'b0;
        drive(d, s, en, g);
    endtask

    task automatic test_reset();
        logic e, a;
        logic saw_one;
        rst_n = 1'b0;
        drive(8'hFF, 3'd0, 1'b1, 1'b0);
        drive(8'hFF, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.DATA_OUT !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0", i, bus.DATA_OUT);
            end
        end
        rst_n = 1'b1;
        since_rel = 0;
        saw_one = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(8'hFF, 3'd0, 1'b1, 1'b0, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i + 1, a, e);
            end
            if (a === 1'b1) saw_one = 1'b1;
        end
        vectors++;
        if (saw_one !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_within_4 got=%b exp=1", saw_one);
        end
    endtask

    task automatic test_basic();
        logic e, a;
        logic [7:0] vals [3];
        vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 20; i++) begin
                step(vals[v], 3'd0, 1'b1, 1'b0, e, a);
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL basic d=%0d cyc=%0d got=%b exp=%b", vals[v], i, a, e);
                end
            end
        end
    endtask

    task automatic test_walk();
        logic e, a;
        for (int i = 0; i < 10; i++) begin
            step(8'hA5, 3'(i % 8), 1'b1, 1'b0, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL walk cyc=%0d got=%b exp=%b", i, a, e);
            end
        end
    endtask

    task automatic test_enable();
        logic e, a;
        logic en;
        for (int i = 0; i < 12; i++) begin
            en = (i < 4 || i >= 8);
            step(8'hFF, 3'd3, en, 1'b0, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL enable cyc=%0d en=%b got=%b exp=%b", i, en, a, e);
            end
        end
    endtask

    task automatic test_inhibit();
        logic e, a;
        logic g;
        logic [2:0] s;
        for (int i = 0; i < 12; i++) begin
            g = (i >= 3 && i < 7);
            s = 3'($urandom_range(0, 7));
            step(8'hFF, s, 1'b1, g, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL inhibit cyc=%0d gnd=%b got=%b exp=%b", i, g, a, e);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic e, a;
        for (int i = 0; i < 14; i++) begin
            step(8'hA5, 3'(i % 8), 1'b1, 1'b0, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL midrun cyc=%0d got=%b exp=%b", i, a, e);
            end
            if (i == 4) begin
                // The output for S=2 (a 1) is in flight, so the clear is visible.
                rst_n = 1'b0;
                #1;
                vectors++;
                if (bus.DATA_OUT !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrun_async_clear got=%b exp=0", bus.DATA_OUT);
                end
                #2;
                rst_n = 1'b1;
                since_rel = 0;
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic e, a;
        logic [7:0] d;
        logic [2:0] s;
        logic en, g;
        for (int i = 0; i < 300; i++) begin
            d  = 8'($urandom);
            s  = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 3) != 0);
            g  = ($urandom_range(0, 7) == 0);
            step(d, s, en, g, e, a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, a, e);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        since_rel   = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h_d[i] = '0; h_s[i] = '0; h_en[i] = 1'b0; h_g[i] = 1'b0;
        end
        drive(8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.DATA_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_initial got=%b exp=0", bus.DATA_OUT);
        end

        test_reset();
        test_basic();
        test_walk();
        test_enable();
        test_inhibit();
        test_midrun_reset();
        test_random_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
